// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin byte arbiter in front of a UART transmitter.
// Holds the grant across a packet until last, a burst cap or an idle timeout.
module uart_tx_arbiter #(
  parameter int unsigned MAX_BURST    = 64,
  parameter int unsigned HOLD_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req0_ready,
  output logic       req1_ready,
  output logic       tx_start,
  output logic [7:0] tx_data,
  input  logic       tx_busy,
  output logic       owner,
  output logic       locked
);

  localparam int unsigned BW = $clog2(MAX_BURST) + 1;
  localparam int unsigned TW = $clog2(HOLD_TIMEOUT) + 1;
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(HOLD_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT_BUSY,
    S_DRAIN,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          owner_q, owner_d;
  logic          locked_q, locked_d;
  logic          last_q, last_d;
  logic          ptr_q, ptr_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [TW-1:0] idle_inc;

  logic [1:0] valid_v;
  logic       win;
  logic       sel;
  logic       accept;

  assign valid_v  = {req1_valid, req0_valid};
  assign idle_inc = idle_q + TW'(1);

  // Pointer side wins unless it is idle, then the other side gets a turn.
  always_comb begin
    win = ptr_q;
    if (!valid_v[ptr_q]) begin
      win = ~ptr_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    owner_d  = owner_q;
    locked_d = locked_q;
    last_d   = last_q;
    ptr_d    = ptr_q;
    burst_d  = burst_q;
    idle_d   = idle_q;
    sel      = owner_q;
    accept   = 1'b0;
    tx_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        sel = win;
        if (rst && !tx_busy && |valid_v) begin
          accept  = 1'b1;
          burst_d = BW'(1);
          state_d = S_START;
        end
      end
      S_START: begin
        tx_start = 1'b1;
        state_d  = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!tx_busy) begin
          idle_d = '0;
          if (!last_q && burst_q < BURST_MAX) begin
            state_d  = S_HOLD;
            locked_d = 1'b1;
          end else begin
            state_d  = S_IDLE;
            locked_d = 1'b0;
            ptr_d    = ~owner_q;
          end
        end
      end
      S_HOLD: begin
        sel = owner_q;
        if (rst && valid_v[owner_q]) begin
          accept  = 1'b1;
          burst_d = burst_q + BW'(1);
          state_d = S_START;
        end else begin
          idle_d = idle_inc;
          if (idle_inc >= IDLE_MAX) begin
            idle_d   = '0;
            state_d  = S_IDLE;
            locked_d = 1'b0;
            ptr_d    = ~owner_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (accept) begin
      data_d  = sel ? req1_data : req0_data;
      last_d  = sel ? req1_last : req0_last;
      owner_d = sel;
      idle_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      owner_q  <= 1'b0;
      locked_q <= 1'b0;
      last_q   <= 1'b0;
      ptr_q    <= 1'b0;
      burst_q  <= '0;
      idle_q   <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      owner_q  <= owner_d;
      locked_q <= locked_d;
      last_q   <= last_d;
      ptr_q    <= ptr_d;
      burst_q  <= burst_d;
      idle_q   <= idle_d;
    end
  end

  assign req0_ready = accept && !sel;
  assign req1_ready = accept && sel;
  assign tx_data    = data_q;
  assign owner      = owner_q;
  assign locked     = locked_q;

endmodule
